// File: rtl/cpu64_l1_line_xfer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu64_l1_line_xfer
// Description : Line-transfer engine between the L1 cache controller and a
//               64-bit beat memory port (req/gnt/rvalid, in-order reads).
//               One accepted command (refill or writeback) is split into
//               LINE_BEATS consecutive 8-byte beat requests; refill data is
//               gathered into a line buffer and completion is signalled by a
//               single-cycle done pulse.
// Ports       : clk_i, rst_ni          - clock / async active-low reset
//               cmd_valid_i/ready_o    - line command handshake
//               cmd_write_i            - 1 = writeback, 0 = refill
//               cmd_addr_i             - line address (offset bits ignored)
//               cmd_wline_i            - writeback line, beat 0 in [63:0]
//               done_o                 - one-cycle completion pulse
//               rline_o                - refill line, beat 0 in [63:0]
//               mem_req_o/we_o/be_o/addr_o/wdata_o - beat request side
//               mem_gnt_i/rvalid_i/rdata_i         - beat response side
// Revision    : 1.0 - initial release
// ============================================================================
module cpu64_l1_line_xfer #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [ADDR_W-1:0]        cmd_addr_i,
    input  logic [64*LINE_BEATS-1:0] cmd_wline_i,
    output logic                     done_o,
    output logic [64*LINE_BEATS-1:0] rline_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [7:0]               mem_be_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [63:0]              mem_wdata_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [63:0]              mem_rdata_i
);

    localparam int c_IDX_W  = $clog2(LINE_BEATS);
    localparam int c_CNT_W  = c_IDX_W + 1;
    localparam int c_OFF_W  = c_IDX_W + 3;
    localparam int c_LINE_W = 64 * LINE_BEATS;
    localparam logic [c_CNT_W-1:0] c_BEATS = c_CNT_W'(LINE_BEATS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_base;
    logic [c_LINE_W-1:0]   r_wline;
    logic [c_LINE_W-1:0]   r_rline;
    logic [c_CNT_W-1:0]    r_issue_cnt;
    logic [c_CNT_W-1:0]    r_recv_cnt;

    logic                  w_accept;
    logic                  w_issue_pend;
    logic                  w_issue_fire;
    logic                  w_recv_fire;
    logic [c_IDX_W-1:0]    w_issue_idx;
    logic [c_IDX_W-1:0]    w_recv_idx;
    logic [ADDR_W-1:0]     w_beat_addr;
    logic                  w_unused_addr_bits;

    // Offset bits of the command address are discarded by line alignment.
    assign w_unused_addr_bits = ^cmd_addr_i[c_OFF_W-1:0];

    assign w_accept    = (r_state == S_IDLE) && cmd_valid_i;
    assign w_issue_idx = r_issue_cnt[c_IDX_W-1:0];
    assign w_recv_idx  = r_recv_cnt[c_IDX_W-1:0];
    // Beat address wraps naturally at ADDR_W bits.
    assign w_beat_addr = r_base + ADDR_W'({w_issue_idx, 3'b000});

    // A refill keeps issuing until all beats are granted, independently of
    // how many read beats have come back so far.
    assign w_issue_pend = (r_state == S_WR) ||
                          ((r_state == S_RD) && (r_issue_cnt < c_BEATS));
    assign w_issue_fire = w_issue_pend && mem_gnt_i;
    assign w_recv_fire  = (r_state == S_RD) && mem_rvalid_i;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 8'h00;
        mem_addr_o  = '0;
        mem_wdata_o = 64'h0;

        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_state_nxt = cmd_write_i ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (w_issue_fire && (r_issue_cnt == c_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RD: begin
                // Completion is driven by the last returned beat, not the
                // last grant.
                if (w_recv_fire && (r_recv_cnt == c_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_issue_pend) begin
            mem_req_o  = 1'b1;
            mem_be_o   = 8'hFF;
            mem_addr_o = w_beat_addr;
            if (r_state == S_WR) begin
                mem_we_o    = 1'b1;
                mem_wdata_o = r_wline[w_issue_idx*64 +: 64];
            end
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_wline     <= '0;
            r_rline     <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_base      <= {cmd_addr_i[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};
                r_wline     <= cmd_wline_i;
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end else begin
                if (w_issue_fire) begin
                    r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
                end
                if (w_recv_fire) begin
                    r_rline[w_recv_idx*64 +: 64] <= mem_rdata_i;
                    r_recv_cnt                   <= r_recv_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign rline_o = r_rline;

endmodule
`default_nettype wire

// File: tb/tb_cpu64_l1_line_xfer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cpu64_l1_line_xfer
// Description : Self-checking bench for cpu64_l1_line_xfer. A line-level
//               reference memory predicts refill contents; a bus-side memory
//               responder with random grant/latency serves the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu64_l1_line_xfer;

    localparam int LB = 4;
    localparam int AW = 64;
    localparam int LW = 64 * LB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_wline = '0;
    logic          done;
    logic [LW-1:0] rline;
    logic          mem_req;
    logic          mem_we;
    logic [7:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [63:0]   mem_rdata = '0;

    cpu64_l1_line_xfer #(.LINE_BEATS(LB), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wline_i(cmd_wline),
        .done_o(done), .rline_o(rline),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic we; logic [7:0] be; logic [63:0] wdata; } beat_t;
    typedef struct { logic [63:0] data; int due; } rsp_t;

    beat_t       obs_q[$];
    rsp_t        pend_q[$];
    bit          gnt_seq[$];
    logic [63:0] bus_mem [bit [AW-1:0]];
    logic [63:0] ref_mem [bit [AW-1:0]];

    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    bit          spurious_en = 1'b0;
    int          done_total = 0;
    int          accept_total = 0;
    int          last_done_cyc = -1;
    int          last_accept_cyc = -1;
    int          hold_viol = 0;

    // Contents of never-written memory: a fixed function of the address.
    function automatic logic [63:0] fill(input logic [AW-1:0] a);
        return {~a[31:0], a[31:0] ^ 32'h5A5A_0F0F};
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~(AW'(LB * 8 - 1));
    endfunction

    // Expected refill line from command-level history of writebacks.
    function automatic logic [LW-1:0] exp_line(input logic [AW-1:0] a);
        logic [LW-1:0] r;
        logic [AW-1:0] b;
        r = '0;
        for (int i = 0; i < LB; i++) begin
            b = align(a) + AW'(8 * i);
            r[64*i +: 64] = ref_mem.exists(b) ? ref_mem[b] : fill(b);
        end
        return r;
    endfunction

    // Bus monitor: records granted beats, backs the bus-side memory, checks
    // that a stalled request holds, counts done pulses and acceptances.
    logic          p_stall = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [63:0]   p_wdata = '0;
    logic          p_we = 1'b0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall && !(mem_req && mem_addr == p_addr && mem_wdata == p_wdata && mem_we == p_we))
                hold_viol++;
            p_stall = mem_req && !mem_gnt;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_we    = mem_we;
            if (mem_req && mem_gnt) begin
                obs_q.push_back('{mem_addr, mem_we, mem_be, mem_wdata});
                if (mem_we) bus_mem[mem_addr] = mem_wdata;
                else pend_q.push_back('{(bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : fill(mem_addr)),
                                       cyc + int'($urandom_range(lat_max, lat_min))});
            end
            if (done) begin
                done_total++;
                last_done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                accept_total++;
                last_accept_cyc = cyc;
            end
        end
    end

    // Memory responder: grant and in-order read data.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                mem_gnt = 1'b0;
            end else begin
                if (mem_req && gnt_seq.size() > 0) mem_gnt = gnt_seq.pop_front();
                else mem_gnt = ($urandom_range(99, 0) < gnt_pct);
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_q[0].data;
                    pend_q.delete(0);
                end else if (spurious_en && (cmd_ready || done || mem_we) && ($urandom_range(1, 0) == 1)) begin
                    // Stray read data while the engine cannot be refilling.
                    mem_rvalid = 1'b1;
                    mem_rdata  = {$urandom, $urandom};
                end
            end
        end
    end

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l, output bit to);
        to = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wline = l;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (cmd_ready) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = {$urandom, $urandom};
        cmd_wline = {8{$urandom}};
        if (!to && wr)
            for (int i = 0; i < LB; i++) ref_mem[align(a) + AW'(8 * i)] = l[64*i +: 64];
    endtask

    task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l, output bit to);
        int d0;
        obs_q.delete();
        d0 = done_total;
        send_cmd(wr, a, l, to);
        for (int i = 0; i < 400 && done_total == d0; i++) begin
            @(negedge clk);
            #2;
        end
        if (done_total == d0) to = 1'b1;
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({cmd_ready, done, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0}) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b done=%b req=%b we=%b be=%h addr=%h wd=%h, want rdy=1 rest 0",
                     cmd_ready, done, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if (rline !== '0) begin
            failures++;
            $display("FAIL reset_rline: got %h want 0", rline);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_writeback_basic;
        logic [LW-1:0] l;
        bit to;
        l = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        gnt_pct = 100;
        run_cmd(1'b1, 64'h1008, l, to);
        checks++;
        if (to) begin failures++; $display("FAIL wb_basic_timeout: got timeout want done"); end
        checks++;
        if (obs_q.size() != LB) begin failures++; $display("FAIL wb_basic_beats: got %0d want %0d", obs_q.size(), LB); end
        for (int i = 0; i < obs_q.size() && i < LB; i++) begin
            checks++;
            if (obs_q[i].addr !== 64'h1000 + AW'(8 * i) || obs_q[i].we !== 1'b1 || obs_q[i].be !== 8'hFF ||
                obs_q[i].wdata !== l[64*i +: 64]) begin
                failures++;
                $display("FAIL wb_basic_beat%0d: got addr=%h we=%b be=%h wd=%h want addr=%h we=1 be=ff wd=%h",
                         i, obs_q[i].addr, obs_q[i].we, obs_q[i].be, obs_q[i].wdata, 64'h1000 + AW'(8 * i), l[64*i +: 64]);
            end
        end
        checks++;
        if (last_done_cyc - last_accept_cyc != LB + 1) begin
            failures++;
            $display("FAIL wb_basic_latency: got %0d want %0d", last_done_cyc - last_accept_cyc, LB + 1);
        end
    endtask

    task automatic test_refill_basic;
        bit to;
        int d0;
        logic [LW-1:0] want;
        want = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        d0 = done_total;
        run_cmd(1'b0, 64'h1000, {8{$urandom}}, to);
        repeat (3) @(negedge clk);
        checks++;
        if (rline !== want || rline !== exp_line(64'h1000)) begin
            failures++;
            $display("FAIL rd_basic_line: got %h want %h", rline, want);
        end
        checks++;
        if (done_total - d0 != 1) begin failures++; $display("FAIL rd_basic_done_count: got %0d want 1", done_total - d0); end
        checks++;
        if (last_done_cyc - last_accept_cyc != LB + 2) begin
            failures++;
            $display("FAIL rd_basic_latency: got %0d want %0d", last_done_cyc - last_accept_cyc, LB + 2);
        end
        checks++;
        if (obs_q.size() != LB || obs_q[0].we !== 1'b0 || obs_q[LB-1].addr !== 64'h1018) begin
            failures++;
            $display("FAIL rd_basic_issue: got n=%0d want n=%0d, we=0, last addr 1018", obs_q.size(), LB);
        end
    endtask

    task automatic test_wb_stall;
        logic [LW-1:0] l;
        bit to;
        int h0;
        l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        gnt_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        h0 = hold_viol;
        run_cmd(1'b1, 64'h2010, l, to);
        checks++;
        if (obs_q.size() != LB) begin failures++; $display("FAIL wb_stall_beats: got %0d want %0d", obs_q.size(), LB); end
        for (int i = 0; i < obs_q.size() && i < LB; i++) begin
            checks++;
            if (obs_q[i].addr !== 64'h2000 + AW'(8 * i) || obs_q[i].wdata !== l[64*i +: 64]) begin
                failures++;
                $display("FAIL wb_stall_beat%0d: got addr=%h wd=%h want addr=%h wd=%h",
                         i, obs_q[i].addr, obs_q[i].wdata, 64'h2000 + AW'(8 * i), l[64*i +: 64]);
            end
        end
        checks++;
        if (hold_viol != h0) begin failures++; $display("FAIL wb_stall_hold: got %0d violations want 0", hold_viol - h0); end
        checks++;
        if (last_done_cyc - last_accept_cyc != LB + 7) begin
            failures++;
            $display("FAIL wb_stall_latency: got %0d want %0d", last_done_cyc - last_accept_cyc, LB + 7);
        end
    endtask

    task automatic test_rd_delayed;
        bit to;
        gnt_pct = 100; lat_min = 8; lat_max = 8;
        run_cmd(1'b0, 64'h2000, '0, to);
        checks++;
        if (obs_q.size() != LB) begin failures++; $display("FAIL rd_delay_req_drop: got %0d grants want %0d", obs_q.size(), LB); end
        checks++;
        if (rline !== exp_line(64'h2000)) begin failures++; $display("FAIL rd_delay_line: got %h want %h", rline, exp_line(64'h2000)); end
        checks++;
        if (last_done_cyc - last_accept_cyc != LB + 9) begin
            failures++;
            $display("FAIL rd_delay_latency: got %0d want %0d", last_done_cyc - last_accept_cyc, LB + 9);
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_mid;
        bit to;
        int d0, n0;
        d0 = done_total;
        obs_q.delete();
        send_cmd(1'b0, 64'h2000, '0, to);
        for (int i = 0; i < 50 && obs_q.size() < 2; i++) begin
            @(negedge clk);
            #2;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, done, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0} ||
            rline !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got rdy=%b done=%b req=%b be=%h addr=%h rline=%h want reset values",
                     cmd_ready, done, mem_req, mem_be, mem_addr, rline);
        end
        n0 = obs_q.size();
        repeat (2) @(negedge clk);
        pend_q.delete();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        checks++;
        if (done_total != d0 || obs_q.size() != n0) begin
            failures++;
            $display("FAIL mid_reset_quiet: got done=%0d reqs=%0d want done=0 reqs=0", done_total - d0, obs_q.size() - n0);
        end
        run_cmd(1'b0, 64'h1000, '0, to);
        checks++;
        if (to || rline !== exp_line(64'h1000)) begin
            failures++;
            $display("FAIL mid_reset_refill: got to=%b line=%h want %h", to, rline, exp_line(64'h1000));
        end
    endtask

    task automatic test_wrap_hold;
        logic [AW-1:0] a;
        int a0, d0, dc, acc2;
        a = 64'hFFFF_FFFF_FFFF_FFE0 | AW'($urandom_range(31, 0));
        obs_q.delete();
        a0 = accept_total; d0 = done_total; dc = -1; acc2 = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (done_total == d0 + 1 && dc < 0) dc = last_done_cyc;
            if (accept_total >= a0 + 2) begin
                acc2 = last_accept_cyc;
                break;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100 && done_total < d0 + 2; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (dc < 0 || acc2 != dc + 1) begin
            failures++;
            $display("FAIL hold_accept_cycle: got accept=%0d want %0d (done=%0d)", acc2, dc + 1, dc);
        end
        checks++;
        if (obs_q.size() != 2 * LB) begin failures++; $display("FAIL wrap_beats: got %0d want %0d", obs_q.size(), 2 * LB); end
        for (int i = 0; i < obs_q.size() && i < LB; i++) begin
            checks++;
            if (obs_q[i].addr !== 64'hFFFF_FFFF_FFFF_FFE0 + AW'(8 * i)) begin
                failures++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, obs_q[i].addr, 64'hFFFF_FFFF_FFFF_FFE0 + AW'(8 * i));
            end
        end
        checks++;
        if (done_total != d0 + 2 || rline !== exp_line(a)) begin
            failures++;
            $display("FAIL wrap_line: got done=%0d line=%h want done=2 line=%h", done_total - d0, rline, exp_line(a));
        end
    endtask

    task automatic test_random;
        bit to, wr, bad;
        logic [AW-1:0] a;
        logic [LW-1:0] l, prev, want;
        int d0;
        gnt_pct = 60; lat_min = 1; lat_max = 4; spurious_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            wr = ($urandom_range(1, 0) == 1);
            a  = 64'h8000 + AW'(32 * $urandom_range(3, 0)) + AW'($urandom_range(31, 0));
            if ($urandom_range(7, 0) == 0) a = {$urandom, $urandom};
            l  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            prev = rline;
            d0 = done_total;
            run_cmd(wr, a, l, to);
            bad = (obs_q.size() != LB);
            for (int i = 0; i < obs_q.size() && i < LB; i++)
                if (obs_q[i].addr !== align(a) + AW'(8 * i) || obs_q[i].we !== wr || obs_q[i].be !== 8'hFF ||
                    obs_q[i].wdata !== (wr ? l[64*i +: 64] : 64'h0)) bad = 1'b1;
            checks++;
            if (to || bad) begin
                failures++;
                $display("FAIL rand%0d_beats: got to=%b n=%0d bad=%b want ordered %0d beats from %h", n, to, obs_q.size(), bad, LB, align(a));
            end
            want = wr ? prev : exp_line(a);
            checks++;
            if (rline !== want || done_total - d0 != 1) begin
                failures++;
                $display("FAIL rand%0d_line: got done=%0d line=%h want done=1 line=%h", n, done_total - d0, rline, want);
            end
        end
        spurious_en = 1'b0;
        checks++;
        if (hold_viol != 0) begin failures++; $display("FAIL rand_hold: got %0d violations want 0", hold_viol); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_writeback_basic();
        test_refill_basic();
        test_wb_stall();
        test_rd_delayed();
        test_reset_mid();
        test_wrap_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
